// File: rtl/fft_twiddle_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_twiddle_addr_gen
//
// Twiddle address generator and fetch sequencer for the radix-2 DIT FFT.
// For a configured length L (N = 2^L) it walks stages s = 0..L-1 and
// butterflies b = 0..2^(L-1)-1. For each pair it issues the packed twiddle
// ROM address. It captures the one-cycle-latency ROM response, together with
// its {s, b} tag, into a small output FIFO. From there the butterfly unit
// drains it over a valid/ready handshake.
//
// Ports
//   clk_i              single clock
//   reset_n_i          asynchronous active-low reset
//   start_i            one-cycle start request, sampled only in IDLE
//   fft_len_log2_i     L, sampled with start_i, legal range 1..MAX
//   busy_o             high from the cycle after an accepted start until done_o
//   done_o             one-cycle pulse after the final twiddle handshake
//   error_o            one-cycle pulse after a start with an illegal L
//   rom_addr_o         packed ROM address {4'b0, k[9:0], k[11:10]}
//   rom_addr_valid_o   ROM read strobe
//   rom_data_i         ROM data {real, imag}, valid one cycle after the strobe
//   rom_data_valid_i   ROM data strobe
//   tw_data_o          twiddle at the FIFO head
//   tw_stage_o         stage tag of the head entry
//   tw_index_o         butterfly index tag of the head entry
//   tw_valid_o         FIFO not empty
//   tw_ready_i         consumer accepts when tw_valid_o & tw_ready_i
// -----------------------------------------------------------------------------
module fft_twiddle_addr_gen #(
    parameter int FFT_MAX_FFT_LENGTH_LOG2 = 12,
    parameter int FIFO_DEPTH              = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [3:0]  fft_len_log2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] rom_addr_o,
    output logic        rom_addr_valid_o,
    input  logic [31:0] rom_data_i,
    input  logic        rom_data_valid_i,
    output logic [31:0] tw_data_o,
    output logic [3:0]  tw_stage_o,
    output logic [10:0] tw_index_o,
    output logic        tw_valid_o,
    input  logic        tw_ready_i
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = 32 + 4 + 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [3:0]          len_q, len_d;
    logic [10:0]         last_b_q, last_b_d;        // 2^(L-1) - 1
    logic [3:0]          cnt_stage_q, cnt_stage_d;  // next position to issue
    logic [10:0]         cnt_bfly_q, cnt_bfly_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    // Address stage: what the ROM sees this cycle
    logic [15:0]         rom_addr_q, rom_addr_d;
    logic                rom_addr_valid_q, rom_addr_valid_d;
    logic [3:0]          addr_stage_q, addr_stage_d;
    logic [10:0]         addr_index_q, addr_index_d;

    // In-flight stage: tag of the request whose data arrives this cycle
    logic                inflight_q, inflight_d;
    logic [3:0]          infl_stage_q, infl_stage_d;
    logic [10:0]         infl_index_q, infl_index_d;

    // Output FIFO: entry = {data[31:0], stage[3:0], index[10:0]}
    logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                len_ok;
    logic [11:0]         start_half;
    logic [10:0]         start_last_b;
    logic                push;
    logic                pop;
    logic [CNT_W:0]      occ;
    logic                credit_ok;
    logic [3:0]          issue_s;
    logic [10:0]         issue_b;
    logic [10:0]         sel_last_b;
    logic [3:0]          adv_s;
    logic [10:0]         adv_b;
    logic [11:0]         exp_mask;
    logic [11:0]         exp_j;
    logic [11:0]         exp_k;
    logic [15:0]         issue_addr;
    logic                do_issue;
    logic [ENTRY_W-1:0]  head;
    logic                last_pop;
    logic [FIFO_DEPTH-1:0] entry_we;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign len_ok       = (fft_len_log2_i != 4'd0) &&
                          (fft_len_log2_i <= 4'(FFT_MAX_FFT_LENGTH_LOG2));
    assign start_half   = 12'd1 << (fft_len_log2_i - 4'd1);
    assign start_last_b = 11'(start_half - 12'd1);

    assign head     = mem_q[rd_ptr_q];
    assign pop      = (count_q != '0) && tw_ready_i;
    // Responses are only trusted when we actually have a request outstanding;
    // anything else (e.g. a response to a pre-reset request) is dropped.
    assign push     = rom_data_valid_i && inflight_q;

    // Everything already committed to land in the FIFO. A pop this cycle
    // frees its slot before any newly issued request can arrive (2 cycles).
    assign occ       = (CNT_W + 1)'(count_q)
                     + (CNT_W + 1)'(rom_addr_valid_q)
                     + (CNT_W + 1)'(inflight_q)
                     - (CNT_W + 1)'(pop);
    assign credit_ok = occ < (CNT_W + 1)'(FIFO_DEPTH);

    // The first request is issued straight from IDLE so the ROM sees it in
    // the cycle right after start; afterwards the counters hold the position.
    always_comb begin
        if (state_q == ST_IDLE) begin
            issue_s    = 4'd0;
            issue_b    = 11'd0;
            sel_last_b = start_last_b;
        end else begin
            issue_s    = cnt_stage_q;
            issue_b    = cnt_bfly_q;
            sel_last_b = last_b_q;
        end
    end

    always_comb begin
        if (issue_b == sel_last_b) begin
            adv_b = 11'd0;
            adv_s = issue_s + 4'd1;
        end else begin
            adv_b = issue_b + 11'd1;
            adv_s = issue_s;
        end
    end

    // k = (b mod 2^s) << (11 - s): exponent in the 4096-point table, so the
    // address depends only on (s, b), never on L.
    assign exp_mask   = (12'd1 << issue_s) - 12'd1;
    assign exp_j      = {1'b0, issue_b} & exp_mask;
    assign exp_k      = exp_j << (4'd11 - issue_s);
    assign issue_addr = {4'b0000, exp_k[9:0], exp_k[11:10]};

    // The final twiddle is recognised by its tag, independent of FIFO fill.
    assign last_pop = pop &&
                      (head[14:11] == (len_q - 4'd1)) &&
                      (head[10:0] == last_b_q);

    // ------------------------------------------------------------------
    // FSM next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        last_b_d         = last_b_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        error_d          = 1'b0;
        do_issue         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        state_d  = ST_RUN;
                        len_d    = fft_len_log2_i;
                        last_b_d = start_last_b;
                        busy_d   = 1'b1;
                        do_issue = 1'b1;
                    end else begin
                        error_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // L = 1 issues its only address from IDLE, so RUN may find
                // nothing left to do.
                if (cnt_stage_q >= len_q) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    do_issue = 1'b1;
                    if (adv_s == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue pipeline
    // ------------------------------------------------------------------
    always_comb begin
        rom_addr_valid_d = do_issue;
        rom_addr_d       = rom_addr_q;
        addr_stage_d     = addr_stage_q;
        addr_index_d     = addr_index_q;
        cnt_stage_d      = cnt_stage_q;
        cnt_bfly_d       = cnt_bfly_q;
        if (do_issue) begin
            rom_addr_d   = issue_addr;
            addr_stage_d = issue_s;
            addr_index_d = issue_b;
            cnt_stage_d  = adv_s;
            cnt_bfly_d   = adv_b;
        end
        // Tag travels one stage behind the address, matching ROM latency.
        inflight_d   = rom_addr_valid_q;
        infl_stage_d = addr_stage_q;
        infl_index_d = addr_index_q;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
            assign entry_we[gi] = push && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (entry_we[i]) begin
                mem_d[i] = {rom_data_i, infl_stage_q, infl_index_q};
            end
        end
        wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q          <= ST_IDLE;
            len_q            <= 4'd0;
            last_b_q         <= 11'd0;
            cnt_stage_q      <= 4'd0;
            cnt_bfly_q       <= 11'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            rom_addr_q       <= 16'd0;
            rom_addr_valid_q <= 1'b0;
            addr_stage_q     <= 4'd0;
            addr_index_q     <= 11'd0;
            inflight_q       <= 1'b0;
            infl_stage_q     <= 4'd0;
            infl_index_q     <= 11'd0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            len_q            <= len_d;
            last_b_q         <= last_b_d;
            cnt_stage_q      <= cnt_stage_d;
            cnt_bfly_q       <= cnt_bfly_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            error_q          <= error_d;
            rom_addr_q       <= rom_addr_d;
            rom_addr_valid_q <= rom_addr_valid_d;
            addr_stage_q     <= addr_stage_d;
            addr_index_q     <= addr_index_d;
            inflight_q       <= inflight_d;
            infl_stage_q     <= infl_stage_d;
            infl_index_q     <= infl_index_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            mem_q            <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign rom_addr_o       = rom_addr_q;
    assign rom_addr_valid_o = rom_addr_valid_q;
    assign tw_data_o        = head[46:15];
    assign tw_stage_o       = head[14:11];
    assign tw_index_o       = head[10:0];
    assign tw_valid_o       = (count_q != '0);

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
module tb_fft_twiddle_addr_gen;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  fft_len_log2_i = 4'd0;
    logic        busy_o, done_o, error_o;
    logic [15:0] rom_addr_o;
    logic        rom_addr_valid_o;
    logic [31:0] rom_data_i;
    logic        rom_data_valid_i;
    logic [31:0] tw_data_o;
    logic [3:0]  tw_stage_o;
    logic [10:0] tw_index_o;
    logic        tw_valid_o;
    logic        tw_ready_i = 1'b0;

    logic        rom_dv_q = 1'b0;
    logic [31:0] rom_data_q = 32'd0;
    logic        stale_inj = 1'b0;
    int          tb_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    fft_twiddle_addr_gen #(
        .FFT_MAX_FFT_LENGTH_LOG2(12),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .start_i(start_i),
        .fft_len_log2_i(fft_len_log2_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .error_o(error_o),
        .rom_addr_o(rom_addr_o),
        .rom_addr_valid_o(rom_addr_valid_o),
        .rom_data_i(rom_data_i),
        .rom_data_valid_i(rom_data_valid_i),
        .tw_data_o(tw_data_o),
        .tw_stage_o(tw_stage_o),
        .tw_index_o(tw_index_o),
        .tw_valid_o(tw_valid_o),
        .tw_ready_i(tw_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Twiddle ROM model: arbitrary but address-unique content, latency 1.
    function automatic logic [31:0] romf(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    function automatic logic [15:0] exp_addr(input int s, input int b);
        int j;
        int k;
        logic [31:0] kv;
        j  = b % (1 << s);
        k  = j * (2048 >> s);
        kv = k;
        return {4'b0000, kv[9:0], kv[11:10]};
    endfunction

    always @(posedge clk_i) begin
        rom_dv_q   <= rom_addr_valid_o;
        rom_data_q <= romf(rom_addr_o);
    end
    assign rom_data_i       = rom_data_q;
    assign rom_data_valid_i = rom_dv_q | stale_inj;

    // Expected FIFO occupancy from the outside: accepted responses minus pops.
    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) tb_cnt <= 0;
        else tb_cnt <= tb_cnt + (rom_dv_q ? 1 : 0) - ((tw_valid_o && tw_ready_i) ? 1 : 0);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({busy_o, done_o, error_o, rom_addr_valid_o, tw_valid_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s flags busy/done/err/av/tv=%b required 00000", name,
                     {busy_o, done_o, error_o, rom_addr_valid_o, tw_valid_o});
        end
        n_checks++;
        if ({rom_addr_o, tw_data_o, tw_stage_o, tw_index_o} !== 63'd0) begin
            n_fail++;
            $display("FAIL %s buses addr=%h data=%h s=%0d b=%0d required all 0", name,
                     rom_addr_o, tw_data_o, tw_stage_o, tw_index_o);
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset_held");
        reset_n_i = 1'b1;
        step();
        step();
        check_all_zero("reset_released");
        $display("reset: checked");
    endtask

    // L = 3 run with ready high; optionally a start with another L mid-run.
    task automatic run_l3(input bit interfere, input string name);
        logic [15:0] exp_a [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                    16'h0000, 16'h0001, 16'h0000, 16'h0001,
                                    16'h0000, 16'h0800, 16'h0001, 16'h0801};
        int na = 0;
        int nt = 0;
        bit seen_done = 0;
        tw_ready_i     = 1'b1;
        fft_len_log2_i = 4'd3;
        start_i        = 1'b1;
        step();
        start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_c1 got %b required 1", name, busy_o);
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (interfere && cyc == 2) begin
                start_i = 1'b1;
                fft_len_log2_i = 4'd5;
            end else begin
                start_i = 1'b0;
            end
            if (rom_addr_valid_o) begin
                n_checks++;
                if (na >= 12 || rom_addr_o !== exp_a[na % 12]) begin
                    n_fail++;
                    $display("FAIL %s addr[%0d] got %h required %h", name, na, rom_addr_o,
                             (na < 12) ? exp_a[na % 12] : 16'hxxxx);
                end
                na++;
            end
            if (tw_valid_o) begin
                $display("%s: tw s=%0d b=%0d data=%h cycle=%0d", name, tw_stage_o, tw_index_o, tw_data_o, cyc);
                if (nt == 0) begin
                    n_checks++;
                    if (cyc != 3) begin
                        n_fail++;
                        $display("FAIL %s first_tw_cycle got %0d required 3", name, cyc);
                    end
                end
                n_checks++;
                if (nt >= 12 || tw_stage_o !== 4'(nt / 4) || tw_index_o !== 11'(nt % 4)
                    || tw_data_o !== romf(exp_a[nt % 12])) begin
                    n_fail++;
                    $display("FAIL %s tw[%0d] got s=%0d b=%0d d=%h required s=%0d b=%0d d=%h", name, nt,
                             tw_stage_o, tw_index_o, tw_data_o, nt / 4, nt % 4, romf(exp_a[nt % 12]));
                end
                nt++;
            end
            if (done_o) begin
                seen_done = 1;
                n_checks++;
                if (cyc != 15 || busy_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s done got cycle=%0d busy=%b required cycle=15 busy=0", name, cyc, busy_o);
                end
            end
            step();
        end
        start_i = 1'b0;
        n_checks++;
        if (na != 12 || nt != 12 || !seen_done) begin
            n_fail++;
            $display("FAIL %s totals got addr=%0d tw=%0d done=%0d required 12 12 1", name, na, nt, seen_done);
        end
    endtask

    task automatic test_n8();
        run_l3(1'b0, "n8");
    endtask

    task automatic test_start_while_busy();
        run_l3(1'b1, "busy_start");
    endtask

    task automatic test_illegal_len();
        logic [3:0] lens [2] = '{4'd0, 4'd13};
        for (int i = 0; i < 2; i++) begin
            fft_len_log2_i = lens[i];
            start_i = 1'b1;
            step();
            start_i = 1'b0;
            $display("illegal: L=%0d error=%b busy=%b", lens[i], error_o, busy_o);
            n_checks++;
            if ({error_o, busy_o, rom_addr_valid_o} !== 3'b100) begin
                n_fail++;
                $display("FAIL illegal_pulse L=%0d got err/busy/av=%b required 100", lens[i],
                         {error_o, busy_o, rom_addr_valid_o});
            end
            step();
            n_checks++;
            if ({error_o, busy_o, rom_addr_valid_o, tw_valid_o} !== 4'b0000) begin
                n_fail++;
                $display("FAIL illegal_after L=%0d got err/busy/av/tv=%b required 0000", lens[i],
                         {error_o, busy_o, rom_addr_valid_o, tw_valid_o});
            end
        end
    endtask

    task automatic test_ready_low();
        int na = 0;
        int nt = 0;
        bit seen_done = 0;
        tw_ready_i     = 1'b0;
        fft_len_log2_i = 4'd3;
        start_i        = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (rom_addr_valid_o) na++;
            step();
        end
        n_checks++;
        if (na != 4) begin
            n_fail++;
            $display("FAIL ready_low_issue got %0d addresses required 4", na);
        end
        n_checks++;
        if (tw_valid_o !== 1'b1 || tw_stage_o !== 4'd0 || tw_index_o !== 11'd0) begin
            n_fail++;
            $display("FAIL ready_low_head got v=%b s=%0d b=%0d required 1 0 0", tw_valid_o, tw_stage_o, tw_index_o);
        end
        tw_ready_i = 1'b1;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (done_o) begin
                seen_done = 1;
            end else begin
                if (rom_addr_valid_o) na++;
                if (tw_valid_o) begin
                    $display("ready_low: tw s=%0d b=%0d data=%h", tw_stage_o, tw_index_o, tw_data_o);
                    n_checks++;
                    if (tw_stage_o !== 4'(nt / 4) || tw_index_o !== 11'(nt % 4)
                        || tw_data_o !== romf(exp_addr(nt / 4, nt % 4))) begin
                        n_fail++;
                        $display("FAIL ready_low_tw[%0d] got s=%0d b=%0d d=%h required s=%0d b=%0d d=%h", nt,
                                 tw_stage_o, tw_index_o, tw_data_o, nt / 4, nt % 4, romf(exp_addr(nt / 4, nt % 4)));
                    end
                    nt++;
                end
                step();
            end
        end
        n_checks++;
        if (na != 12 || nt != 12 || !seen_done) begin
            n_fail++;
            $display("FAIL ready_low_totals got addr=%0d tw=%0d done=%0d required 12 12 1", na, nt, seen_done);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        bit found = 0;
        int na = 0;
        int nt = 0;
        bit seen_done = 0;
        tw_ready_i     = 1'b1;
        fft_len_log2_i = 4'd4;
        start_i        = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (tw_valid_o && tw_stage_o == 4'd1) found = 1;
            else step();
        end
        tw_ready_i = 1'b0;
        step();
        step();
        n_checks++;
        if (!found || tb_cnt != 3 || rom_data_valid_i !== 1'b1 || tw_stage_o !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_mid_setup got found=%0d cnt=%0d inflight=%b s=%0d required 1 3 1 1",
                     found, tb_cnt, rom_data_valid_i, tw_stage_o);
        end
        reset_n_i = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        stale_inj = 1'b1;
        step();
        stale_inj = 1'b0;
        n_checks++;
        if (tw_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_drop got tv=%b busy=%b required 0 0", tw_valid_o, busy_o);
        end
        tw_ready_i     = 1'b1;
        fft_len_log2_i = 4'd1;
        start_i        = 1'b1;
        step();
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (rom_addr_valid_o) begin
                n_checks++;
                if (rom_addr_o !== 16'h0000 || cyc != 1) begin
                    n_fail++;
                    $display("FAIL l1_addr got %h at cycle %0d required 0000 at 1", rom_addr_o, cyc);
                end
                na++;
            end
            if (tw_valid_o) begin
                $display("l1: tw s=%0d b=%0d data=%h cycle=%0d", tw_stage_o, tw_index_o, tw_data_o, cyc);
                n_checks++;
                if (tw_stage_o !== 4'd0 || tw_index_o !== 11'd0 || tw_data_o !== romf(16'h0000) || cyc != 3) begin
                    n_fail++;
                    $display("FAIL l1_tw got s=%0d b=%0d d=%h cycle=%0d required 0 0 %h 3",
                             tw_stage_o, tw_index_o, tw_data_o, cyc, romf(16'h0000));
                end
                nt++;
            end
            if (done_o) begin
                seen_done = 1;
                n_checks++;
                if (cyc != 4) begin
                    n_fail++;
                    $display("FAIL l1_done got cycle %0d required 4", cyc);
                end
            end
            step();
        end
        n_checks++;
        if (na != 1 || nt != 1 || !seen_done) begin
            n_fail++;
            $display("FAIL l1_totals got addr=%0d tw=%0d done=%0d required 1 1 1", na, nt, seen_done);
        end
    endtask

    task automatic test_l12_random();
        int as_ = 0, ab = 0, ts = 0, tb = 0, na = 0, nt = 0;
        bit seen_done = 0;
        logic prev_v = 0, prev_r = 0;
        logic [31:0] prev_d = 0;
        logic [3:0]  prev_s = 0;
        logic [10:0] prev_b = 0;
        fft_len_log2_i = 4'd12;
        tw_ready_i     = 1'b0;
        start_i        = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 60000 && !seen_done && n_fail < 40; c++) begin
            if (done_o) begin
                seen_done = 1;
            end else begin
                tw_ready_i = 1'($urandom_range(0, 1));
                if (rom_addr_valid_o) begin
                    n_checks++;
                    if (rom_addr_o !== exp_addr(as_, ab)) begin
                        n_fail++;
                        $display("FAIL l12_addr s=%0d b=%0d got %h required %h", as_, ab, rom_addr_o, exp_addr(as_, ab));
                    end
                    na++;
                    ab++;
                    if (ab == 2048) begin ab = 0; as_++; end
                end
                n_checks++;
                if (tb_cnt > 4) begin
                    n_fail++;
                    $display("FAIL l12_occupancy got %0d required <= 4", tb_cnt);
                end
                if (tw_valid_o) begin
                    if (prev_v && !prev_r) begin
                        n_checks++;
                        if (tw_data_o !== prev_d || tw_stage_o !== prev_s || tw_index_o !== prev_b) begin
                            n_fail++;
                            $display("FAIL l12_stall got %h/%0d/%0d required %h/%0d/%0d",
                                     tw_data_o, tw_stage_o, tw_index_o, prev_d, prev_s, prev_b);
                        end
                    end
                    n_checks++;
                    if (tw_stage_o !== 4'(ts) || tw_index_o !== 11'(tb) || tw_data_o !== romf(exp_addr(ts, tb))) begin
                        n_fail++;
                        $display("FAIL l12_tw got s=%0d b=%0d d=%h required s=%0d b=%0d d=%h",
                                 tw_stage_o, tw_index_o, tw_data_o, ts, tb, romf(exp_addr(ts, tb)));
                    end
                    if (tw_ready_i) begin
                        nt++;
                        tb++;
                        if (tb == 2048) begin
                            $display("l12: stage %0d delivered", ts);
                            tb = 0;
                            ts++;
                        end
                    end
                end
                prev_v = tw_valid_o;
                prev_r = tw_ready_i;
                prev_d = tw_data_o;
                prev_s = tw_stage_o;
                prev_b = tw_index_o;
                step();
            end
        end
        n_checks++;
        if (na != 24576 || nt != 24576 || !seen_done) begin
            n_fail++;
            $display("FAIL l12_totals got addr=%0d tw=%0d done=%0d required 24576 24576 1", na, nt, seen_done);
        end
        tw_ready_i = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_n8();
        test_start_while_busy();
        test_illegal_len();
        test_ready_low();
        test_reset_mid_run();
        test_l12_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
